// File: rtl/pb_cmd_pkg.sv
// Purpose  : shared encodings for the push-button command sequencer.
// Latency  : n/a (types, constants and pure helper functions only).
// Backpres.: n/a.
// Contents : cmd_e (button index == command code), state_e (FSM encoding),
//            prio_pick (fixed-priority one-hot pick), gnt2cmd (grant -> command).
package pb_cmd_pkg;

   localparam int unsigned NUM_PB = 3;

   // Command code equals the index of the button that produces it.
   typedef enum logic [1:0] {
      CMD_INC  = 2'd0,
      CMD_CLR  = 2'd1,
      CMD_SHOW = 2'd2
   } cmd_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2
   } state_e;

   // Fixed priority: pb2 > pb1 > pb0. Result is one-hot or zero.
   function automatic logic [NUM_PB-1:0] prio_pick(input logic [NUM_PB-1:0] req);
      logic [NUM_PB-1:0] gnt;
      gnt = '0;
      if (req[2])      gnt[2] = 1'b1;
      else if (req[1]) gnt[1] = 1'b1;
      else if (req[0]) gnt[0] = 1'b1;
      return gnt;
   endfunction

   // Only meaningful for a one-hot grant; a zero grant maps to INC but is never written.
   function automatic cmd_e gnt2cmd(input logic [NUM_PB-1:0] gnt);
      cmd_e c;
      if (gnt[2])      c = CMD_SHOW;
      else if (gnt[1]) c = CMD_CLR;
      else             c = CMD_INC;
      return c;
   endfunction

endpackage

// File: rtl/pb_debounce.sv
// Purpose  : debounce one active-low raw push-button and emit a one-cycle press event.
// Latency  : deb rises DEB_LEN+2 edges after the first edge that samples a stable 0.
// Backpres.: none; press is a single-cycle event that the consumer must capture.
// Ports    : clock, reset_n (async active-low), noisy (raw button, 0 = pressed),
//            deb (debounced level, 1 = pressed), press (one cycle on deb rising edge).
module pb_debounce #(
   parameter int unsigned DEB_LEN = 8
) (
   input  logic clock,
   input  logic reset_n,
   input  logic noisy,
   output logic deb,
   output logic press
);

   logic               sync1_q;
   logic               sync2_q;
   logic [DEB_LEN-1:0] shift_q;
   logic               deb_q;
   logic               deb_d;
   logic               deb_prev_q;

   // Hysteresis: only a full window of identical samples moves the state;
   // any mixed window keeps the previous decision.
   always_comb begin
      deb_d = deb_q;
      if (shift_q == '0) begin
         deb_d = 1'b1;
      end else if (&shift_q) begin
         deb_d = 1'b0;
      end
   end

   // Reset leaves everything in the "released" condition so a button held
   // through reset is seen as a fresh press once the window fills with zeros.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         shift_q    <= '1;
         deb_q      <= 1'b0;
         deb_prev_q <= 1'b0;
      end else begin
         sync1_q    <= noisy;
         sync2_q    <= sync1_q;
         shift_q    <= {shift_q[DEB_LEN-2:0], sync2_q};
         deb_q      <= deb_d;
         deb_prev_q <= deb_q;
      end
   end

   assign deb   = deb_q;
   assign press = deb_q & ~deb_prev_q;

endmodule

// File: rtl/pb_cmd_sequencer.sv
// Purpose  : turn debounced button presses into queued INC/CLR/SHOW commands and execute them.
// Latency  : E0+DEB_LEN+6 edges from first sampled press to visible result (idle, uncontended).
// Backpres.: FIFO full stalls grants and holds pending; a repeat press on a held pending bit sets overflow.
// Ports    : clock, reset_n (async active-low), pb[2:0] (raw, 0 = pressed; INC/CLR/SHOW),
//            led (~count at last SHOW), busy (FSM active or queue non-empty), overflow (sticky lost press).
module pb_cmd_sequencer
   import pb_cmd_pkg::*;
#(
   parameter int unsigned DEB_LEN = 8,
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned QDEPTH  = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [2:0]        pb,
   output logic [CNT_W-1:0]  led,
   output logic              busy,
   output logic              overflow
);

   localparam int unsigned PTR_W  = $clog2(QDEPTH);
   localparam int unsigned QCNT_W = PTR_W + 1;
   localparam logic [QCNT_W-1:0] FIFO_FULL = QCNT_W'(QDEPTH);

   // ------------------------------------------------------------------
   // Debouncers
   // ------------------------------------------------------------------
   logic [NUM_PB-1:0] deb_w;
   logic [NUM_PB-1:0] press_w;

   for (genvar g = 0; g < NUM_PB; g++) begin : g_deb
      pb_debounce #(
         .DEB_LEN (DEB_LEN)
      ) u_deb (
         .clock   (clock),
         .reset_n (reset_n),
         .noisy   (pb[g]),
         .deb     (deb_w[g]),
         .press   (press_w[g])
      );
   end

   // ------------------------------------------------------------------
   // Pending bits and arbiter
   // ------------------------------------------------------------------
   logic [NUM_PB-1:0] pending_q;
   logic [NUM_PB-1:0] pending_d;
   logic [NUM_PB-1:0] grant;
   logic              push;
   cmd_e              wr_cmd;
   logic              merge_drop;

   logic [QCNT_W-1:0] fifo_cnt_q;
   logic [QCNT_W-1:0] fifo_cnt_d;
   logic              fifo_empty;
   logic              can_push;

   assign fifo_empty = (fifo_cnt_q == '0);
   assign can_push   = (fifo_cnt_q < FIFO_FULL);

   // Grant looks only at the registered count, so a pop in the same cycle
   // does not open a slot early (no write bypass).
   assign grant  = can_push ? prio_pick(pending_q) : '0;
   assign push   = |grant;
   assign wr_cmd = gnt2cmd(grant);

   // A press landing on a bit that stays set this cycle is merged away.
   // A press on a bit being granted right now simply re-arms it.
   assign merge_drop = |(press_w & pending_q & ~grant);
   assign pending_d  = (pending_q & ~grant) | press_w;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   // ------------------------------------------------------------------
   // Command FIFO
   // ------------------------------------------------------------------
   cmd_e             fifo_mem_q [QDEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic             pop;

   always_comb begin
      fifo_cnt_d = fifo_cnt_q;
      if (push && !pop) begin
         fifo_cnt_d = fifo_cnt_q + QCNT_W'(1);
      end else if (!push && pop) begin
         fifo_cnt_d = fifo_cnt_q - QCNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         fifo_cnt_q <= fifo_cnt_d;
      end
   end

   // Storage needs no reset: entries are only read behind the count.
   always_ff @(posedge clock) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q] <= wr_cmd;
      end
   end

   // ------------------------------------------------------------------
   // Execution FSM
   // ------------------------------------------------------------------
   state_e state_q;
   state_e state_d;
   cmd_e   cmd_q;
   logic   exec;

   // The head is popped on the IDLE->FETCH edge so cmd_q holds it during
   // FETCH; the command retires on the FETCH->EXEC edge, making its result
   // visible for the whole EXEC cycle. EXEC then returns to IDLE.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      exec    = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = FETCH;
            end
         end
         FETCH: begin
            exec    = 1'b1;
            state_d = EXEC;
         end
         EXEC: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cmd_q   <= CMD_INC;
      end else begin
         state_q <= state_d;
         if (pop) cmd_q <= fifo_mem_q[rd_ptr_q];
      end
   end

   // ------------------------------------------------------------------
   // Datapath: counter, display, overflow flag
   // ------------------------------------------------------------------
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic [CNT_W-1:0] led_q;
   logic [CNT_W-1:0] led_d;
   logic             overflow_q;
   logic             overflow_d;

   always_comb begin
      count_d    = count_q;
      led_d      = led_q;
      overflow_d = overflow_q;
      if (exec) begin
         case (cmd_q)
            CMD_INC:  count_d = count_q + CNT_W'(1);
            CMD_CLR: begin
               count_d    = '0;
               overflow_d = 1'b0;
            end
            CMD_SHOW: led_d = ~count_q;
            default:  count_d = count_q;
         endcase
      end
      // A lost press in the same cycle as a CLR must still be reported.
      if (merge_drop) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q    <= '0;
         led_q      <= '1;
         overflow_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         led_q      <= led_d;
         overflow_q <= overflow_d;
      end
   end

   assign led      = led_q;
   assign overflow = overflow_q;
   assign busy     = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_pb_cmd_sequencer.sv
// Purpose  : directed self-checking bench for pb_cmd_sequencer (DEB_LEN=4, CNT_W=8, QDEPTH=4).
// Latency  : n/a.
// Backpres.: FSM is held in EXEC by force where a full queue is needed.
module tb_pb_cmd_sequencer;
   import pb_cmd_pkg::*;

   logic       clock;
   logic       reset_n;
   logic [2:0] pb;
   logic [7:0] led;
   logic       busy;
   logic       overflow;

   int checks = 0;
   int errors = 0;

   pb_cmd_sequencer #(
      .DEB_LEN (4),
      .CNT_W   (8),
      .QDEPTH  (4)
   ) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .pb       (pb),
      .led      (led),
      .busy     (busy),
      .overflow (overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Active-high mask of buttons to press together; held 10 cycles, then released.
   task automatic press(input logic [2:0] m);
      pb = ~m;
      tick(10);
      pb = 3'b111;
      tick(14);
   endtask

   initial begin
      pb      = 3'b111;
      reset_n = 1'b0;
      tick(3);
      chk("rst_led", led, 8'hFF);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ovf", overflow, 1'b0);
      reset_n = 1'b1;
      tick(2);
      chk("rst_count", dut.count_q, 8'h00);

      // 1. Clean INC, then a timed SHOW: E0 is the next edge after driving.
      press(3'b001);
      chk("t1_count", dut.count_q, 8'h01);
      chk("t1_led_hold", led, 8'hFF);
      pb[2] = 1'b0;
      tick(8);
      chk("t1_busy_pending_only", busy, 1'b0);
      tick(1);
      chk("t1_busy_queued", busy, 1'b1);
      tick(1);
      chk("t1_led_e9", led, 8'hFF);
      tick(1);
      chk("t1_led_e10", led, 8'hFE);
      pb[2] = 1'b1;
      tick(14);

      // 2. Bouncing input never forms a press.
      for (int i = 0; i < 20; i++) begin
         pb[0] = ~pb[0];
         tick(1);
         chk("t2_busy_bounce", busy, 1'b0);
      end
      pb = 3'b111;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         chk("t2_busy_after", busy, 1'b0);
      end
      chk("t2_count", dut.count_q, 8'h01);

      // 3. Simultaneous press with count=5: SHOW, CLR, INC.
      for (int i = 0; i < 4; i++) press(3'b001);
      chk("t3_count5", dut.count_q, 8'h05);
      press(3'b111);
      chk("t3_led", led, 8'hFA);
      chk("t3_count", dut.count_q, 8'h01);
      chk("t3_ovf", overflow, 1'b0);

      // 4. Counter wrap.
      press(3'b010);
      chk("t4_clr", dut.count_q, 8'h00);
      for (int i = 0; i < 255; i++) press(3'b001);
      chk("t4_count255", dut.count_q, 8'hFF);
      press(3'b001);
      chk("t4_wrap", dut.count_q, 8'h00);
      press(3'b100);
      chk("t4_led", led, 8'hFF);

      // 5. Full queue plus held pending, then a merged press.
      force dut.state_q = EXEC;
      for (int i = 0; i < 5; i++) press(3'b001);
      chk("t5_full_no_ovf", overflow, 1'b0);
      chk("t5_busy", busy, 1'b1);
      chk("t5_fifo_cnt", dut.fifo_cnt_q, 3'd4);
      chk("t5_pending", dut.pending_q, 3'b001);
      press(3'b001);
      chk("t5_ovf_set", overflow, 1'b1);
      release dut.state_q;
      tick(30);
      chk("t5_count", dut.count_q, 8'h05);
      chk("t5_ovf_sticky", overflow, 1'b1);
      chk("t5_idle", busy, 1'b0);
      press(3'b010);
      chk("t5_ovf_clr", overflow, 1'b0);
      chk("t5_count_clr", dut.count_q, 8'h00);

      // 6. Reset pulse with three commands queued.
      press(3'b001);
      press(3'b100);
      chk("t6_led_pre", led, 8'hFE);
      force dut.state_q = EXEC;
      press(3'b111);
      chk("t6_queued", dut.fifo_cnt_q, 3'd3);
      chk("t6_busy_pre", busy, 1'b1);
      release dut.state_q;
      reset_n = 1'b0;
      #1;
      chk("t6_rst_led", led, 8'hFF);
      chk("t6_rst_busy", busy, 1'b0);
      chk("t6_rst_ovf", overflow, 1'b0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick(1);
         chk("t6_busy_after", busy, 1'b0);
      end
      chk("t6_led_after", led, 8'hFF);
      chk("t6_count_after", dut.count_q, 8'h00);

      // 7. Button held through reset release gives exactly one press.
      pb = 3'b110;
      reset_n = 1'b0;
      tick(1);
      reset_n = 1'b1;
      tick(30);
      chk("t7_one_press", dut.count_q, 8'h01);
      pb = 3'b111;
      tick(20);
      chk("t7_still_one", dut.count_q, 8'h01);
      chk("t7_idle", busy, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
